// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pixel pipe: entity word layout, orientation encoding,
// geometry and the RGB222 palette used when SPRITE_COLOUR_EN is defined.
package sprite_pkg;

    localparam int UPSCALE_FACTOR = 5;
    localparam int TILE_SIZE      = 8;
    localparam int H_ACTIVE       = 640;
    localparam int V_ACTIVE       = 480;
    localparam int PIPE_LAT       = 2;

    localparam logic [8:0] ENTITY_NONE = 9'h1FF;

    localparam int LINE_HI   = 8;
    localparam int LINE_LO   = 6;
    localparam int TILE_HI   = 5;
    localparam int TILE_LO   = 2;
    localparam int ORIENT_HI = 1;
    localparam int ORIENT_LO = 0;

    localparam int ORIENT_HMIRROR_BIT = 0;
    localparam int ORIENT_VMIRROR_BIT = 1;

    typedef logic [5:0] rgb222_t;

    function automatic rgb222_t palette_lookup(input logic [3:0] tile);
        rgb222_t colour;
        case (tile)
            4'h0:    colour = 6'h15;
            4'h1:    colour = 6'h2A;
            4'h2:    colour = 6'h03;
            4'h3:    colour = 6'h0C;
            4'h4:    colour = 6'h0F;
            4'h5:    colour = 6'h30;
            4'h6:    colour = 6'h33;
            4'h7:    colour = 6'h3C;
            4'h8:    colour = 6'h01;
            4'h9:    colour = 6'h04;
            4'hA:    colour = 6'h10;
            4'hB:    colour = 6'h05;
            4'hC:    colour = 6'h11;
            4'hD:    colour = 6'h14;
            4'hE:    colour = 6'h2F;
            4'hF:    colour = 6'h3F;
            default: colour = 6'h00;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// 128x8 sprite tile ROM, address {tile, line}, one-cycle registered read; bit 7 is the leftmost pixel.
module sprite_rom
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] addr,
    output logic [7:0] row
);

    logic [7:0] rom_data_s;

    // Tile bitmap contents; rows not listed are blank.
    always_comb begin
        rom_data_s = 8'h00;
        case (addr)
            7'h00:   rom_data_s = 8'h00;
            7'h08:   rom_data_s = 8'h18;
            7'h09:   rom_data_s = 8'h3C;
            7'h13:   rom_data_s = 8'h81;
            7'h14:   rom_data_s = 8'h0F;
            7'h1B:   rom_data_s = 8'hC0;
            7'h28:   rom_data_s = 8'hF0;
            7'h29:   rom_data_s = 8'h0F;
            7'h78:   rom_data_s = 8'hFF;
            7'h7F:   rom_data_s = 8'hAA;
            default: rom_data_s = 8'h00;
        endcase
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            row <= 8'h00;
        end else begin
            row <= rom_data_s;
        end
    end

endmodule

// File: rtl/sprite_pixel_pipe.sv
// Two-stage sprite pixel pipe: column tracking, orientation, ROM lookup and delay-matched syncs.
// Optional colour output and palette are built when SPRITE_COLOUR_EN is defined.
module sprite_pixel_pipe
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] entity_in,
    input  logic [9:0] counter_H,
    input  logic [9:0] counter_V,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic       pixel_on,
    output logic       pixel_valid,
    output logic       hsync_out,
    output logic       vsync_out
`ifdef SPRITE_COLOUR_EN
    ,
    output logic [5:0] colour_out
`endif
);

    localparam logic [2:0] SUB_LAST  = 3'(UPSCALE_FACTOR - 1);
    localparam logic [2:0] COL_LAST  = 3'(TILE_SIZE - 1);
    localparam logic [9:0] TILE_SPAN = 10'(TILE_SIZE * UPSCALE_FACTOR);
    localparam logic [9:0] UPSCALE   = 10'(UPSCALE_FACTOR);

    logic [9:0] prev_h_r;
    logic [2:0] sub_cnt_r;
    logic [2:0] col_cnt_r;
    logic [2:0] sub_cnt_s;
    logic [2:0] col_cnt_s;

    logic [2:0] line_s;
    logic [3:0] tile_s;
    logic [1:0] orient_s;
    logic [2:0] line_mir_s;
    logic [2:0] col_mir_s;
    logic       valid_s;

    logic       valid_r;
    logic [2:0] column_r;
    logic       hsync_r;
    logic       vsync_r;
    logic [7:0] rom_row_s;
    logic       pixel_s;

    // Column position of the current pixel: restart at 0, step on consecutive H, resync on any jump.
    always_comb begin
        sub_cnt_s = 3'd0;
        col_cnt_s = 3'd0;
        if (counter_H == 10'd0) begin
            sub_cnt_s = 3'd0;
            col_cnt_s = 3'd0;
        end else if (counter_H == prev_h_r + 10'd1) begin
            if (sub_cnt_r == SUB_LAST) begin
                sub_cnt_s = 3'd0;
                col_cnt_s = (col_cnt_r == COL_LAST) ? 3'd0 : col_cnt_r + 3'd1;
            end else begin
                sub_cnt_s = sub_cnt_r + 3'd1;
                col_cnt_s = col_cnt_r;
            end
        end else begin
            sub_cnt_s = 3'(counter_H % UPSCALE);
            col_cnt_s = 3'((counter_H % TILE_SPAN) / UPSCALE);
        end
    end

    // Tracker state remembers the previous pixel so the next one can step from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_h_r  <= 10'd0;
            sub_cnt_r <= 3'd0;
            col_cnt_r <= 3'd0;
        end else begin
            prev_h_r  <= counter_H;
            sub_cnt_r <= sub_cnt_s;
            col_cnt_r <= col_cnt_s;
        end
    end

    // Decode the entity word and apply both mirrors before the ROM address is formed.
    always_comb begin
        line_s     = entity_in[LINE_HI:LINE_LO];
        tile_s     = entity_in[TILE_HI:TILE_LO];
        orient_s   = entity_in[ORIENT_HI:ORIENT_LO];
        line_mir_s = orient_s[ORIENT_VMIRROR_BIT] ? (COL_LAST - line_s) : line_s;
        col_mir_s  = orient_s[ORIENT_HMIRROR_BIT] ? (COL_LAST - col_cnt_s) : col_cnt_s;
        valid_s    = (entity_in != ENTITY_NONE) &&
                     (counter_H < 10'(H_ACTIVE)) &&
                     (counter_V < 10'(V_ACTIVE));
    end

    // The ROM register is the stage-1 copy of the row, so stage 2 can register pixel_on directly.
    sprite_rom u_rom (
        .clk   (clk),
        .reset (reset),
        .addr  ({tile_s, line_mir_s}),
        .row   (rom_row_s)
    );

    // Stage 1: column, validity and syncs travel alongside the ROM read.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r  <= 1'b0;
            column_r <= 3'd0;
            hsync_r  <= 1'b1;
            vsync_r  <= 1'b1;
        end else begin
            valid_r  <= valid_s;
            column_r <= col_mir_s;
            hsync_r  <= hsync_in;
            vsync_r  <= vsync_in;
        end
    end

    always_comb begin
        pixel_s = valid_r & rom_row_s[3'd7 - column_r];
    end

    // Stage 2: registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b0;
            hsync_out   <= 1'b1;
            vsync_out   <= 1'b1;
        end else begin
            pixel_on    <= pixel_s;
            pixel_valid <= valid_r;
            hsync_out   <= hsync_r;
            vsync_out   <= vsync_r;
        end
    end

`ifdef SPRITE_COLOUR_EN
    logic [3:0] tile_r;

    // Palette path: tile follows stage 1, colour is registered with stage 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            tile_r     <= 4'd0;
            colour_out <= 6'h00;
        end else begin
            tile_r     <= tile_s;
            colour_out <= pixel_s ? palette_lookup(tile_r) : 6'h00;
        end
    end
`endif

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Scoreboard bench for sprite_pixel_pipe: expected outputs are queued when stimulus is driven
// and compared two cycles later.
module tb_sprite_pixel_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] entity_in;
    logic [9:0] counter_H;
    logic [9:0] counter_V;
    logic       hsync_in;
    logic       vsync_in;
    logic       pixel_on;
    logic       pixel_valid;
    logic       hsync_out;
    logic       vsync_out;
`ifdef SPRITE_COLOUR_EN
    logic [5:0] colour_out;
`endif

    typedef struct packed {
        logic       on;
        logic       valid;
        logic       hs;
        logic       vs;
        logic [5:0] colour;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam exp_t RESET_ITEM = '{on: 1'b0, valid: 1'b0, hs: 1'b1, vs: 1'b1, colour: 6'h00};

    sprite_pixel_pipe dut (
        .clk         (clk),
        .reset       (reset),
        .entity_in   (entity_in),
        .counter_H   (counter_H),
        .counter_V   (counter_V),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .pixel_on    (pixel_on),
        .pixel_valid (pixel_valid),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
`ifdef SPRITE_COLOUR_EN
        ,
        .colour_out  (colour_out)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_row(input logic [3:0] tile, input logic [2:0] line);
        logic [7:0] r;
        case ({tile, line})
            7'h00:   r = 8'h00;
            7'h13:   r = 8'h81;
            7'h14:   r = 8'h0F;
            7'h1B:   r = 8'hC0;
            7'h28:   r = 8'hF0;
            7'h78:   r = 8'hFF;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] ref_pal(input logic [3:0] tile);
        logic [5:0] c;
        case (tile)
            4'h2:    c = 6'h03;
            4'h3:    c = 6'h0C;
            4'h5:    c = 6'h30;
            4'hF:    c = 6'h3F;
            default: c = 6'h00;
        endcase
        return c;
    endfunction

    function automatic exp_t model(input logic [8:0] e, input logic [9:0] h, input logic [9:0] v,
                                   input logic hs, input logic vs);
        exp_t       x;
        logic [2:0] line;
        logic [2:0] col;
        logic [7:0] row;
        x.valid  = (e != 9'h1FF) && (h < 10'd640) && (v < 10'd480);
        line     = e[1] ? 3'd7 - e[8:6] : e[8:6];
        col      = 3'((int'(h) % 40) / 5);
        row      = ref_row(e[5:2], line);
        x.on     = x.valid && (e[0] ? row[col] : row[3'd7 - col]);
        x.colour = x.on ? ref_pal(e[5:2]) : 6'h00;
        x.hs     = hs;
        x.vs     = vs;
        return x;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t x);
        check({tag, "_on"},    {7'd0, pixel_on},    {7'd0, x.on});
        check({tag, "_valid"}, {7'd0, pixel_valid}, {7'd0, x.valid});
        check({tag, "_hsync"}, {7'd0, hsync_out},   {7'd0, x.hs});
        check({tag, "_vsync"}, {7'd0, vsync_out},   {7'd0, x.vs});
`ifdef SPRITE_COLOUR_EN
        check({tag, "_colour"}, {2'd0, colour_out}, {2'd0, x.colour});
`endif
    endtask

    task automatic step(input string tag, input logic [8:0] e, input logic [9:0] h,
                        input logic [9:0] v);
        logic hs;
        logic vs;
        exp_t x;
        hs        = 1'($urandom_range(0, 1));
        vs        = 1'($urandom_range(0, 1));
        reset     = 1'b0;
        entity_in = e;
        counter_H = h;
        counter_V = v;
        hsync_in  = hs;
        vsync_in  = vs;
        exp_q.push_back(model(e, h, v, hs, vs));
        @(posedge clk);
        #1;
        if (exp_q.size() >= 2) begin
            x = exp_q.pop_front();
            compare_all(tag, x);
        end
    endtask

    task automatic reset_step(input logic [8:0] e, input logic [9:0] h);
        reset     = 1'b1;
        entity_in = e;
        counter_H = h;
        counter_V = 10'd0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        @(posedge clk);
        #1;
        compare_all("reset", RESET_ITEM);
        exp_q.delete();
        exp_q.push_back(RESET_ITEM);
    endtask

    localparam logic [8:0] W_PLAIN = {3'd3, 4'd2, 2'b00};
    localparam logic [8:0] W_HMIR  = {3'd3, 4'd3, 2'b01};
    localparam logic [8:0] W_VMIR  = {3'd4, 4'd2, 2'b10};
    localparam logic [8:0] W_T15   = 9'h1FE;
    localparam logic [8:0] W_T5    = {3'd0, 4'd5, 2'b00};

    initial begin
        reset_step(9'h000, 10'd0);
        reset_step(9'h000, 10'd0);

        for (int h = 0; h < 40; h++) step("plain", W_PLAIN, 10'(h), 10'd10);
        for (int h = 0; h < 40; h++) step("hmirror", W_HMIR, 10'(h), 10'd10);
        for (int h = 0; h < 40; h++) step("vmirror", W_VMIR, 10'(h), 10'd11);
        for (int h = 0; h < 10; h++) step("tile15", W_T15, 10'(h), 10'd12);
        for (int h = 0; h < 40; h++) step("tile5", W_T5, 10'(h), 10'd13);

        for (int h = 10; h < 18; h++) step("prejump", W_PLAIN, 10'(h), 10'd14);
        for (int h = 123; h < 128; h++) step("jump", W_PLAIN, 10'(h), 10'd14);

        for (int h = 636; h < 646; h++) step("hedge", W_PLAIN, 10'(h), 10'd15);
        for (int h = 0; h < 10; h++) step("vedge", W_PLAIN, 10'(h), 10'd480);
        for (int h = 0; h < 5; h++) step("vlast", W_PLAIN, 10'(h), 10'd479);

        for (int h = 0; h < 660; h++) step("none", 9'h1FF, 10'(h), 10'd20);

        for (int h = 0; h < 10; h++) step("preRst", W_PLAIN, 10'(h), 10'd21);
        for (int h = 10; h < 13; h++) reset_step(9'h000, 10'(h));
        for (int h = 13; h < 25; h++) step("postRst", W_PLAIN, 10'(h), 10'd21);

        step("drain", 9'h1FF, 10'd0, 10'd22);
        step("drain", 9'h1FF, 10'd1, 10'd22);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
